// File: rtl/dsp_v6_pkg.sv
// Shared definitions for the v6 IIR datapath: FSM state encoding,
// accumulator sizing, saturation limits and the round/saturate helper.
package dsp_v6_pkg;

  localparam int unsigned PKG_REG_WIDTH = 16;
  localparam int unsigned PKG_FRAC      = 14;
  localparam int unsigned PKG_VECTOR    = 6;

  // Three full products plus two guard bits cannot overflow the sum.
  localparam int unsigned ACC_W = 2 * PKG_REG_WIDTH + 2;

  localparam logic signed [ACC_W-1:0] MAX_S =
    {{(ACC_W - PKG_REG_WIDTH + 1){1'b0}}, {(PKG_REG_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_S =
    {{(ACC_W - PKG_REG_WIDTH + 1){1'b1}}, {(PKG_REG_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic                     sat;
    logic [PKG_REG_WIDTH-1:0] val;
  } sat_res_t;

  // Round half toward +inf, drop frac bits, clamp to a reg_width signed range.
  function automatic sat_res_t sat_round(input logic signed [ACC_W-1:0] sum,
                                         input int unsigned frac,
                                         input int unsigned reg_width);
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shr;
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    logic signed [ACC_W-1:0] clamped;
    sat_res_t                r;
    rnd     = sum + (ACC_W'(1) << (frac - 1));
    shr     = rnd >>> frac;
    max_v   = (ACC_W'(1) << (reg_width - 1)) - ACC_W'(1);
    min_v   = ~max_v;
    r.sat   = 1'b0;
    clamped = shr;
    if (shr > max_v) begin
      clamped = max_v;
      r.sat   = 1'b1;
    end else if (shr < min_v) begin
      clamped = min_v;
      r.sat   = 1'b1;
    end
    r.val = PKG_REG_WIDTH'(clamped);
    return r;
  endfunction

endpackage

// File: rtl/delay_element_v6.sv
// Unreset state register closing the IIR recursion: registers the new
// x/y state pair every cycle.
// Ports: clk; a_n_1/b_n_1 new state in; a_n/b_n previous state out.
module delay_element_v6 #(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned VECTOR    = 6
) (
  input  logic                        clk,
  input  logic [REG_WIDTH*VECTOR-1:0] a_n_1,
  input  logic [REG_WIDTH*VECTOR-1:0] b_n_1,
  output logic [REG_WIDTH*VECTOR-1:0] a_n,
  output logic [REG_WIDTH*VECTOR-1:0] b_n
);

  always_ff @(posedge clk) begin
    a_n <= a_n_1;
    b_n <= b_n_1;
  end

endmodule

// File: rtl/iir_lane_v6.sv
// One IIR lane: captures x, x_prev, y_prev on accept, forms the three
// products, then rounds/saturates the sum into the new state pair.
// Ports: clk/rst; capture_i/mul_en_i/acc_en_i step strobes from the shared
// FSM; b0_i/b1_i/a1_i captured coefficients; x_i/xp_i/yp_i lane inputs;
// x_o/y_o new state; sat_o sticky saturation flag, cleared by sat_clr_i.
module iir_lane_v6
  import dsp_v6_pkg::*;
#(
  parameter int unsigned REG_WIDTH = PKG_REG_WIDTH,
  parameter int unsigned FRAC      = PKG_FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture_i,
  input  logic                 mul_en_i,
  input  logic                 acc_en_i,
  input  logic                 sat_clr_i,
  input  logic [REG_WIDTH-1:0] b0_i,
  input  logic [REG_WIDTH-1:0] b1_i,
  input  logic [REG_WIDTH-1:0] a1_i,
  input  logic [REG_WIDTH-1:0] x_i,
  input  logic [REG_WIDTH-1:0] xp_i,
  input  logic [REG_WIDTH-1:0] yp_i,
  output logic [REG_WIDTH-1:0] x_o,
  output logic [REG_WIDTH-1:0] y_o,
  output logic                 sat_o
);

  localparam int unsigned PW = 2 * REG_WIDTH;

  logic signed [REG_WIDTH-1:0] x_q, xp_q, yp_q;
  logic signed [PW-1:0]        p0_q, p1_q, p2_q;
  logic signed [PW-1:0]        p0_d, p1_d, p2_d;
  logic signed [ACC_W-1:0]     sum_c;
  sat_res_t                    res_c;
  logic [REG_WIDTH-1:0]        x_out_q, y_out_q;
  logic                        sat_q;

  // Full-precision products and the guarded sum.
  always_comb begin
    p0_d  = PW'($signed(b0_i)) * PW'(x_q);
    p1_d  = PW'($signed(b1_i)) * PW'(xp_q);
    p2_d  = PW'($signed(a1_i)) * PW'(yp_q);
    sum_c = ACC_W'(p0_q) + ACC_W'(p1_q) + ACC_W'(p2_q);
    res_c = sat_round(sum_c, FRAC, REG_WIDTH);
  end

  // Lane pipeline registers; a new saturation beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      xp_q    <= '0;
      yp_q    <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (capture_i) begin
        x_q  <= $signed(x_i);
        xp_q <= $signed(xp_i);
        yp_q <= $signed(yp_i);
      end
      if (mul_en_i) begin
        p0_q <= p0_d;
        p1_q <= p1_d;
        p2_q <= p2_d;
      end
      if (acc_en_i) begin
        x_out_q <= x_q;
        y_out_q <= REG_WIDTH'(res_c.val);
      end
      if (acc_en_i && res_c.sat) begin
        sat_q <= 1'b1;
      end else if (sat_clr_i) begin
        sat_q <= 1'b0;
      end
    end
  end

  assign x_o   = x_out_q;
  assign y_o   = y_out_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/iir_update_v6.sv
// Vector first-order IIR update stage feeding delay_element_v6.
// Ports: clk/rst; in_valid/in_ready accept handshake; x_in sample vector;
// coef_b0/coef_b1/coef_a1 shared coefficients (a1 pre-negated); a_n/b_n
// previous x/y from the delay element; a_n_1/b_n_1 new x/y state;
// out_valid result pulse; sat_flag sticky per-lane flags, sat_clr clears.
module iir_update_v6
  import dsp_v6_pkg::*;
#(
  parameter int unsigned REG_WIDTH = PKG_REG_WIDTH,
  parameter int unsigned FRAC      = PKG_FRAC,
  parameter int unsigned VECTOR    = PKG_VECTOR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [REG_WIDTH*VECTOR-1:0] x_in,
  input  logic [REG_WIDTH-1:0]        coef_b0,
  input  logic [REG_WIDTH-1:0]        coef_b1,
  input  logic [REG_WIDTH-1:0]        coef_a1,
  input  logic [REG_WIDTH*VECTOR-1:0] a_n,
  input  logic [REG_WIDTH*VECTOR-1:0] b_n,
  output logic [REG_WIDTH*VECTOR-1:0] a_n_1,
  output logic [REG_WIDTH*VECTOR-1:0] b_n_1,
  output logic                        out_valid,
  output logic [VECTOR-1:0]           sat_flag,
  input  logic                        sat_clr
);

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [REG_WIDTH-1:0] b0_q, b1_q, a1_q;
  logic                 accept_c;
  logic                 mul_en_c;
  logic                 acc_en_c;

  assign accept_c = in_valid && in_ready_q;
  assign mul_en_c = (state_q == ST_MUL);
  assign acc_en_c = (state_q == ST_ACC);

  // Next state; ready tracks the state being entered so it is registered.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_MUL;
      ST_MUL:  state_d = ST_ACC;
      ST_ACC:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_q == ST_ACC);
  end

  // FSM, handshake and shared coefficient registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      a1_q        <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      if (accept_c) begin
        b0_q <= coef_b0;
        b1_q <= coef_b1;
        a1_q <= coef_a1;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  for (genvar i = 0; i < int'(VECTOR); i++) begin : g_lane
    iir_lane_v6 #(
      .REG_WIDTH(REG_WIDTH),
      .FRAC     (FRAC)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .capture_i(accept_c),
      .mul_en_i (mul_en_c),
      .acc_en_i (acc_en_c),
      .sat_clr_i(sat_clr),
      .b0_i     (b0_q),
      .b1_i     (b1_q),
      .a1_i     (a1_q),
      .x_i      (x_in[i*REG_WIDTH +: REG_WIDTH]),
      .xp_i     (a_n[i*REG_WIDTH +: REG_WIDTH]),
      .yp_i     (b_n[i*REG_WIDTH +: REG_WIDTH]),
      .x_o      (a_n_1[i*REG_WIDTH +: REG_WIDTH]),
      .y_o      (b_n_1[i*REG_WIDTH +: REG_WIDTH]),
      .sat_o    (sat_flag[i])
    );
  end

endmodule

// File: tb/tb_iir_update_v6.sv
// Directed bench: iir_update_v6 closed through delay_element_v6.
module tb_iir_update_v6;

  localparam int RW  = 16;
  localparam int VEC = 6;
  localparam int W   = RW * VEC;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x_in;
  logic [RW-1:0]  coef_b0, coef_b1, coef_a1;
  logic [W-1:0]   a_n, b_n, a_n_1, b_n_1;
  logic           out_valid;
  logic [VEC-1:0] sat_flag;
  logic           sat_clr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir_update_v6 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_a1(coef_a1),
    .a_n(a_n), .b_n(b_n), .a_n_1(a_n_1), .b_n_1(b_n_1),
    .out_valid(out_valid), .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  delay_element_v6 u_dly (
    .clk(clk), .a_n_1(a_n_1), .b_n_1(b_n_1), .a_n(a_n), .b_n(b_n)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Offer one vector, wait for its result; returns at the negedge after k+2.
  task automatic send(input logic [RW-1:0] x, output logic [W-1:0] y,
                      output logic [W-1:0] xo, output int lat,
                      output int acc_cyc);
    int n;
    x_in     = {VEC{x}};
    in_valid = 1'b1;
    n        = 0;
    lat      = 99;
    acc_cyc  = 0;
    y        = '0;
    xo       = '0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_accept: in_ready=%b need 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    x_in     = {VEC{16'hDEAD}};
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    y  = b_n_1;
    xo = a_n_1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    x_in     = '0;
    coef_b0  = '0;
    coef_b1  = '0;
    coef_a1  = '0;
    tick();
    tick();
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_in_ready: got %b need 0", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0 || sat_flag !== '0) begin
      fails++;
      $display("FAIL reset_flags: out_valid=%b sat_flag=%h need 0/00",
               out_valid, sat_flag);
    end
    tests++;
    if (a_n_1 !== '0 || b_n_1 !== '0) begin
      fails++; $display("FAIL reset_state: a_n_1=%h b_n_1=%h need 0", a_n_1, b_n_1);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b need 1", in_ready);
    end
  endtask

  task automatic test_passthrough();
    logic [W-1:0] y, xo;
    int lat, ac;
    do_reset();
    coef_b0 = 16'h4000; coef_b1 = 16'h0000; coef_a1 = 16'h0000;
    send(16'h1000, y, xo, lat, ac);
    tests++;
    if (lat !== 2) begin
      fails++; $display("FAIL pass_latency: got %0d need 2", lat);
    end
    tests++;
    if (y !== {VEC{16'h1000}}) begin
      fails++; $display("FAIL pass_y: got %h need %h", y, {VEC{16'h1000}});
    end
    tests++;
    if (xo !== {VEC{16'h1000}}) begin
      fails++; $display("FAIL pass_x: got %h need %h", xo, {VEC{16'h1000}});
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || b_n_1 !== {VEC{16'h1000}}) begin
      fails++;
      $display("FAIL pass_pulse_hold: out_valid=%b b_n_1=%h need 0/%h",
               out_valid, b_n_1, {VEC{16'h1000}});
    end
  endtask

  task automatic test_recursion();
    logic [RW-1:0] xs[4]  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    logic [RW-1:0] exp[4] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    logic [W-1:0] y, xo;
    int lat, ac, prev;
    do_reset();
    coef_b0 = 16'h4000; coef_b1 = 16'h0000; coef_a1 = 16'h2000;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], y, xo, lat, ac);
      tests++;
      if (y !== {VEC{exp[i]}}) begin
        fails++; $display("FAIL recur_y%0d: got %h need %h", i, y, {VEC{exp[i]}});
      end
      if (i > 0) begin
        tests++;
        if (ac - prev !== 4) begin
          fails++; $display("FAIL recur_spacing%0d: got %0d need 4", i, ac - prev);
        end
      end
      prev = ac;
    end
  endtask

  task automatic test_saturation();
    logic [RW-1:0] xs[4]  = '{16'h6000, 16'h6000, 16'hA000, 16'hA000};
    logic [RW-1:0] exp[4] = '{16'h6000, 16'h7FFF, 16'h0000, 16'h8000};
    logic [VEC-1:0] fexp[4] = '{6'h00, 6'h3F, 6'h3F, 6'h3F};
    logic [W-1:0] y, xo;
    int lat, ac;
    do_reset();
    coef_b0 = 16'h4000; coef_b1 = 16'h4000; coef_a1 = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], y, xo, lat, ac);
      tests++;
      if (y !== {VEC{exp[i]}} || sat_flag !== fexp[i]) begin
        fails++;
        $display("FAIL sat_step%0d: y=%h flag=%h need %h/%h",
                 i, y, sat_flag, {VEC{exp[i]}}, fexp[i]);
      end
    end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    tests++;
    if (sat_flag !== 6'h00) begin
      fails++; $display("FAIL sat_clear: got %h need 00", sat_flag);
    end
    // Clear held across a saturating result: the set must win.
    sat_clr = 1'b1;
    send(16'hA000, y, xo, lat, ac);
    tests++;
    if (y !== {VEC{16'h8000}} || sat_flag !== 6'h3F) begin
      fails++;
      $display("FAIL sat_set_wins: y=%h flag=%h need %h/3f", y, sat_flag, {VEC{16'h8000}});
    end
    sat_clr = 1'b0;
    tick();
  endtask

  task automatic test_rounding();
    logic [RW-1:0] xs[3]  = '{16'h0001, 16'hFFFF, 16'h0003};
    logic [RW-1:0] exp[3] = '{16'h0001, 16'h0000, 16'h0002};
    logic [W-1:0] y, xo;
    int lat, ac;
    do_reset();
    coef_b0 = 16'h2000; coef_b1 = 16'h0000; coef_a1 = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      send(xs[i], y, xo, lat, ac);
      tests++;
      if (y !== {VEC{exp[i]}}) begin
        fails++; $display("FAIL round%0d: got %h need %h", i, y, {VEC{exp[i]}});
      end
    end
  endtask

  task automatic test_handshake();
    int accepts, low_cnt, prev, bad_gap;
    do_reset();
    coef_b0 = 16'h4000; coef_b1 = 16'h0000; coef_a1 = 16'h0000;
    accepts = 0; low_cnt = 0; prev = 0; bad_gap = 0;
    x_in     = {VEC{16'h0100}};
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (in_ready !== 1'b1) low_cnt++;
      else begin
        if (accepts > 0 && cyc - prev != 4) bad_gap++;
        prev = cyc;
        accepts++;
      end
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (accepts !== 3) begin
      fails++; $display("FAIL hs_accepts: got %0d need 3", accepts);
    end
    tests++;
    if (low_cnt !== 9) begin
      fails++; $display("FAIL hs_ready_low: got %0d need 9", low_cnt);
    end
    tests++;
    if (bad_gap !== 0) begin
      fails++; $display("FAIL hs_spacing: bad gaps %0d need 0", bad_gap);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] y, xo;
    int lat, ac, n;
    do_reset();
    coef_b0 = 16'h4000; coef_b1 = 16'h0000; coef_a1 = 16'h0000;
    send(16'h1000, y, xo, lat, ac);
    tests++;
    if (y !== {VEC{16'h1000}}) begin
      fails++; $display("FAIL midop_pre: got %h need %h", y, {VEC{16'h1000}});
    end
    x_in     = {VEC{16'h1234}};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    tick();            // accept edge k
    in_valid = 1'b0;
    tick();            // k+1: now in ACC
    rst = 1'b1;
    tick();            // k+2: reset instead of result
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midop_flags: out_valid=%b in_ready=%b need 0/0", out_valid, in_ready);
    end
    tests++;
    if (a_n_1 !== '0 || b_n_1 !== '0) begin
      fails++; $display("FAIL midop_zero: a_n_1=%h b_n_1=%h need 0", a_n_1, b_n_1);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midop_release: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    x_in     = '0;
    coef_b0  = '0;
    coef_b1  = '0;
    coef_a1  = '0;
    test_reset();
    test_passthrough();
    test_recursion();
    test_saturation();
    test_rounding();
    test_handshake();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/iir_update_v6.md
# iir_update_v6

Vector first-order IIR update stage. It sits directly upstream of `delay_element_v6` and closes the recursion through it. Each accepted sample vector is combined with the previous input and output vectors (the delay element's `a_n`/`b_n`) and the block produces the new input/output state pair (`a_n_1`/`b_n_1`) that the delay element registers. All lanes run in lock-step; the output is rounded and saturated, with sticky per-lane overflow flags.

## Interface

- `REG_WIDTH`, 16: sample and coefficient width, signed two's complement.
- `FRAC`, 14: fractional bits of samples and coefficients (Q(REG_WIDTH-FRAC).FRAC); must satisfy 1 ≤ FRAC < REG_WIDTH.
- `VECTOR`, 6: number of parallel lanes.

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: `x_in` holds a valid sample vector.
- `in_ready` out 1: block can accept; transfer occurs when `in_valid` and `in_ready` are both high at a rising edge.
- `x_in` in REG_WIDTH×VECTOR: input sample x[n] per lane.
- `coef_b0`, `coef_b1`, `coef_a1` in REG_WIDTH each: shared coefficients. `coef_a1` is pre-negated, so y = b0·x + b1·x_prev + a1·y_prev.
- `a_n` in REG_WIDTH×VECTOR: x[n-1] from the delay element.
- `b_n` in REG_WIDTH×VECTOR: y[n-1] from the delay element.
- `a_n_1` out REG_WIDTH×VECTOR: x[n], to the delay element.
- `b_n_1` out REG_WIDTH×VECTOR: y[n], to the delay element; also the filter output.
- `out_valid` out 1: one-cycle pulse when `b_n_1` carries a new result.
- `sat_flag` out VECTOR: sticky per-lane saturation flag.
- `sat_clr` in 1: clears `sat_flag`.

## Operation

- The FSM has four states: IDLE → MUL → ACC → WAIT → IDLE.
  - IDLE: `in_ready`=1. On handshake, capture `x_in`, `a_n`, `b_n` and the three coefficients into lane registers, then go to MUL.
  - MUL: register the three full products per lane, each 2·REG_WIDTH bits signed.
  - ACC: form the sum at 2·REG_WIDTH+2 bits. Add 2^(FRAC-1) (round half toward +∞), arithmetic-shift right by FRAC, then saturate to REG_WIDTH. Register the result to `b_n_1`, register the captured x to `a_n_1`, and pulse `out_valid`.
  - WAIT: one cycle so the delay element captures the new state before the next accept.
- Saturation clamps positive overflow to 2^(REG_WIDTH-1)-1 and negative overflow to -2^(REG_WIDTH-1). Each lane's clamp sets its `sat_flag` bit.
- If `sat_clr` and a new saturation occur in the same cycle, the set wins.
- `a_n_1`/`b_n_1` hold their value between updates.
- `x_in` and the coefficients are ignored outside IDLE. `in_valid` deasserting after an accept has no effect on the operation in flight.

## Timing

- Reset (synchronous, takes effect at the edge where `rst`=1):
  - FSM goes to IDLE.
  - `in_ready`=0 while `rst` is high, and 1 from the first edge after `rst` falls.
  - `a_n_1`, `b_n_1`, `sat_flag` = 0; `out_valid`=0.
- `rst` must be held at least 2 cycles so the unreset delay element loads zeros.
- Reset mid-operation aborts the sample: no `out_valid`, and state is zeroed.
- Latency: accept at edge k → `b_n_1` and `out_valid` valid after edge k+2. The delay element updates at k+3. `in_ready` is high again after k+3.
- Throughput: one vector per 4 cycles with `in_valid` held high.
- `a_n`/`b_n` are sampled only at the accept edge.

## Structure

- Shared package `dsp_v6_pkg` holds:
  - the FSM state enum (IDLE, MUL, ACC, WAIT);
  - the function `sat_round(sum, FRAC, REG_WIDTH)`;
  - the localparams `ACC_W = 2*REG_WIDTH+2`, `MAX_S`, `MIN_S`.
- One natural sub-module, `iir_lane_v6`: a single lane's capture/MUL/ACC datapath and its saturation flag, instantiated VECTOR times under a shared FSM.
- Bench instantiates `iir_update_v6` plus `delay_element_v6` in a feedback loop.

## Test plan

- Passthrough. Setup: b0=0x4000, b1=0, a1=0. Stimulus: x=0x1000 all lanes. Response: `b_n_1`=0x1000 and `out_valid` pulse two edges after accept; `a_n_1`=0x1000.
- Recursion. Setup: b0=0x4000, a1=0x2000. Stimulus: impulse x=0x4000, then zeros. Response: y = 0x4000, 0x2000, 0x1000, 0x0800, with accepts every 4 cycles.
- Saturation. Setup: b0=b1=0x4000, then back-to-back samples. Stimulus and response:
  - x=0x6000 twice → y=0x7FFF.
  - x=0xA000 twice → y=0x8000.
  - In both cases `sat_flag` sets on all lanes, stays set, and clears one cycle after a `sat_clr` pulse.
- Rounding. Setup: b0=0x2000. Response: x=0x0001 → y=0x0001; x=0xFFFF → y=0x0000; x=0x0003 → y=0x0002.
- Handshake. Stimulus: `in_valid` held high for 12 cycles. Response: exactly 3 accepts, spaced 4 cycles apart; `in_ready` low in MUL/ACC/WAIT.
- Reset mid-operation. Stimulus: assert `rst` in ACC. Response: no `out_valid`; outputs are 0 after that edge; `in_ready`=1 on the first edge after `rst` falls.
